// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: multi-byte I2C master (7-bit addressing, read/write, ACK checking).
// Drives open-drain enables only; the top level builds the tristate pads.
// Optional feature macro: CLK_STRETCH_EN (slave may stretch SCL during Q1).
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 31,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       slave_addr,
  input  logic [LEN_W-1:0] num_bytes,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_error,
  input  logic             sda_i,
  input  logic             scl_i,
  output logic             sda_oe,
  output logic             scl_oe
);
  localparam int unsigned QCNT_W = 8;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_WAIT, WRITE, WR_ACK, READ, RD_ACK, STOP
  } state_t;

  state_t            state, state_d;
  logic [QCNT_W-1:0] qcnt, qcnt_d;
  logic [1:0]        q, q_d;
  logic [2:0]        bitcnt, bitcnt_d;
  logic [LEN_W-1:0]  cnt, cnt_d;
  logic [7:0]        shreg, shreg_d;
  logic [6:0]        addr_q, addr_d;
  logic              rw_q, rw_d, ack_bit, ack_bit_d;
  logic              sda_oe_d, scl_oe_d, tx_ready_d, rx_valid_d, busy_d, done_d, ack_error_d;
  logic [7:0]        rx_data_d;
  logic              tick_c, adv_c, q0_first_c, sample_c, bit_state_c, stretch_c;

`ifdef CLK_STRETCH_EN
  // Slave holds SCL low after we released it: keep Q1 from expiring
  assign stretch_c = (q == 2'd1) && !scl_oe && !scl_i;
`else
  logic scl_i_unused;
  assign scl_i_unused = scl_i;
  assign stretch_c    = 1'b0;
`endif

  assign tick_c      = (qcnt == QCNT_W'(CLK_DIV - 1));
  assign adv_c       = tick_c && !stretch_c;
  assign q0_first_c  = (q == 2'd0) && (qcnt == '0);
  assign sample_c    = (q == 2'd2) && (qcnt == '0);
  assign bit_state_c = (state == ADDR) || (state == ADDR_ACK) || (state == WRITE) ||
                       (state == WR_ACK) || (state == READ) || (state == RD_ACK);

  // State register
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state, timebase and output logic
  always_comb begin
    state_d     = state;
    qcnt_d      = qcnt;
    q_d         = q;
    bitcnt_d    = bitcnt;
    cnt_d       = cnt;
    shreg_d     = shreg;
    addr_d      = addr_q;
    rw_d        = rw_q;
    ack_bit_d   = ack_bit;
    sda_oe_d    = sda_oe;
    scl_oe_d    = scl_oe;
    tx_ready_d  = tx_ready;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    busy_d      = busy;
    ack_error_d = ack_error;

    // Quarter timebase; frozen while idle or waiting for a write byte
    if (state != IDLE && state != WR_WAIT) begin
      if (stretch_c)   qcnt_d = '0;
      else if (tick_c) begin
        qcnt_d = '0;
        q_d    = q + 2'd1;
      end else         qcnt_d = qcnt + QCNT_W'(1);
    end

    // SCL waveform shared by all bit slots: release after Q0, pull after Q3
    if (bit_state_c && adv_c) begin
      if (q == 2'd0) scl_oe_d = 1'b0;
      if (q == 2'd3) scl_oe_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_d     = START;
          rw_d        = rw;
          addr_d      = slave_addr;
          cnt_d       = num_bytes;
          ack_error_d = 1'b0;
          busy_d      = 1'b1;
          qcnt_d      = '0;
          q_d         = '0;
        end
      end
      START: begin
        if (adv_c && q == 2'd1) sda_oe_d = 1'b1;
        if (adv_c && q == 2'd2) begin
          scl_oe_d = 1'b1;
          state_d  = ADDR;
          q_d      = '0;
          bitcnt_d = 3'd7;
          shreg_d  = {addr_q, rw_q};
        end
      end
      ADDR, WRITE: begin
        if (q0_first_c) sda_oe_d = !shreg[7];
        if (adv_c && q == 2'd3) begin
          shreg_d  = {shreg[6:0], 1'b0};
          bitcnt_d = bitcnt - 3'd1;
          if (bitcnt == 3'd0) state_d = (state == ADDR) ? ADDR_ACK : WR_ACK;
        end
      end
      ADDR_ACK, WR_ACK: begin
        if (q0_first_c) sda_oe_d  = 1'b0;
        if (sample_c)   ack_bit_d = sda_i;
        if (adv_c && q == 2'd3) begin
          if (ack_bit) begin
            ack_error_d = 1'b1;
            state_d     = STOP;
          end else if (state == ADDR_ACK) begin
            if (cnt == '0) state_d = STOP;
            else if (rw_q) begin
              state_d  = READ;
              bitcnt_d = 3'd7;
            end else begin
              state_d    = WR_WAIT;
              tx_ready_d = 1'b1;
            end
          end else begin
            if (cnt != '0) cnt_d = cnt - LEN_W'(1);
            if (cnt <= LEN_W'(1)) state_d = STOP;
            else begin
              state_d    = WR_WAIT;
              tx_ready_d = 1'b1;
            end
          end
        end
      end
      WR_WAIT: begin
        if (tx_ready && tx_valid) begin
          shreg_d    = tx_data;
          tx_ready_d = 1'b0;
          state_d    = WRITE;
          bitcnt_d   = 3'd7;
          qcnt_d     = '0;
          q_d        = '0;
        end
      end
      READ: begin
        if (q0_first_c) sda_oe_d = 1'b0;
        if (sample_c) begin
          shreg_d = {shreg[6:0], sda_i};
          if (bitcnt == 3'd0) begin
            rx_data_d  = {shreg[6:0], sda_i};
            rx_valid_d = 1'b1;
          end
        end
        if (adv_c && q == 2'd3) begin
          bitcnt_d = bitcnt - 3'd1;
          if (bitcnt == 3'd0) state_d = RD_ACK;
        end
      end
      RD_ACK: begin
        if (q0_first_c) sda_oe_d = (cnt > LEN_W'(1));
        if (adv_c && q == 2'd3) begin
          if (cnt != '0) cnt_d = cnt - LEN_W'(1);
          if (cnt <= LEN_W'(1)) state_d = STOP;
          else begin
            state_d  = READ;
            bitcnt_d = 3'd7;
          end
        end
      end
      STOP: begin
        if (q0_first_c) sda_oe_d = 1'b1;
        if (adv_c) begin
          if (q == 2'd0) scl_oe_d = 1'b0;
          if (q == 2'd2) sda_oe_d = 1'b0;
          if (q == 2'd3) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers; reset releases both lines at once
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      qcnt      <= '0;
      q         <= '0;
      bitcnt    <= '0;
      cnt       <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      ack_bit   <= 1'b0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      tx_ready  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      qcnt      <= qcnt_d;
      q         <= q_d;
      bitcnt    <= bitcnt_d;
      cnt       <= cnt_d;
      shreg     <= shreg_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      ack_bit   <= ack_bit_d;
      sda_oe    <= sda_oe_d;
      scl_oe    <= scl_oe_d;
      tx_ready  <= tx_ready_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      ack_error <= ack_error_d;
    end
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Parametrised I2C master controller for the avionics sensor bus. It supersedes the fixed single-byte master.
- Runs multi-byte read or write transfers to any 7-bit address, with a programmable SCL rate and ACK/NACK checking.
- Data moves through valid/ready byte handshakes.
- Open-drain controls only; the top level builds the tristates (line = oe ? 0 : z).

Parameters:
- CLK_DIV, 31: clk_50 cycles per SCL quarter-period. SCL period = 4*CLK_DIV cycles (31 gives 403 kHz). Legal range 2..255.
- LEN_W, 4: width of num_bytes. Maximum transfer is 2^LEN_W-1 bytes.

Ports:
- clk_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle transfer request; sampled only in IDLE
- rw  in  1  0 = write, 1 = read; latched on start
- slave_addr  in  7  target address; latched on start
- num_bytes  in  LEN_W  data bytes to move; latched on start
- tx_data  in  8  write byte
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller wants a byte
- rx_data  out  8  last byte read
- rx_valid  out  1  one-cycle strobe, rx_data new
- busy  out  1  transfer in progress
- done  out  1  one-cycle strobe at end of STOP
- ack_error  out  1  slave NACKed; held until next start
- sda_i  in  1  SDA line state
- scl_i  in  1  SCL line state
- sda_oe  out  1  1 = pull SDA low
- scl_oe  out  1  1 = pull SCL low

Behaviour:
- Reset (asynchronous, any state): go to IDLE.
  - sda_oe = scl_oe = 0; busy, done, ack_error, tx_ready, rx_valid = 0; rx_data = 0x00.
  - Lines are released immediately, mid-bit included; no STOP is generated.
- Timing: a quarter-tick counter counts 0..CLK_DIV-1 and runs only when busy. Every bit takes 4 quarters:
  - Q0: SCL low; drive SDA.
  - Q1: release SCL.
  - Q2: SCL high; sample sda_i at the start of Q2.
  - Q3: SCL high; pull SCL low at the end of Q3.
- States: IDLE, START, ADDR, ADDR_ACK, WR_WAIT, WRITE, WR_ACK, READ, RD_ACK, STOP.
- IDLE -> START on start=1. In the same cycle: latch rw, slave_addr and num_bytes, clear ack_error, set busy=1. start while busy is ignored.
- START: 2 quarters with SDA released and SCL high, then pull SDA low. After 1 quarter pull SCL low, then go to ADDR.
- ADDR: shift {slave_addr, rw} MSB first, 8 bits. ADDR_ACK: release SDA and sample.
  - sda_i = 1: ack_error = 1, go to STOP.
  - num_bytes = 0: go to STOP (address probe).
  - Otherwise: rw = 0 -> WR_WAIT; rw = 1 -> READ.
- WR_WAIT: hold SCL low with tx_ready = 1. Wait indefinitely until tx_valid = 1.
  - When tx_ready & tx_valid: latch tx_data, drop tx_ready the next cycle, go to WRITE.
- WRITE: 8 bits MSB first. WR_ACK: sample.
  - NACK: ack_error = 1, go to STOP.
  - ACK: decrement the byte counter; if 0 go to STOP, else WR_WAIT.
- READ: release SDA and sample 8 bits MSB first. After bit 0: update rx_data and pulse rx_valid in the same cycle.
- RD_ACK: drive ACK (sda_oe = 1) when bytes remain, NACK (release) on the last byte. Then go to READ or STOP.
- STOP: Q0 pull SDA low; Q1 release SCL; Q3 release SDA.
  - One quarter later: pulse done, busy = 0, go to IDLE.
- Byte counter is LEN_W bits and decrements without wrap; it is checked for 0 before decrementing.
- sda_oe changes only while SCL is held low, except in START and STOP.

Optional Feature:
- CLK_STRETCH_EN: when defined, the quarter counter freezes in Q1 while scl_oe = 0 and scl_i = 0 (slave stretching). Q2 starts CLK_DIV cycles after scl_i is seen high.
- Without it, scl_i is ignored and timing is fixed.

Test Plan:
- Write, CLK_DIV=4, addr 0x1B, num_bytes=2, bytes 0xA5 then 0x3C, slave ACKs all -> SDA bits 0x36, 0xA5, 0x3C; two tx_ready handshakes; done after STOP; ack_error=0; SCL period 16 cycles.
- Read, addr 0x1B, num_bytes=3, slave sends 0x11, 0x22, 0x33 -> address byte 0x37; rx_valid x3 with matching rx_data; master ACK, ACK, NACK; STOP.
- Address NACK (sda_i held 1), write of 2 bytes -> ack_error=1; no tx_ready; STOP; done pulse.
- num_bytes=0 probe -> START, address, ACK, STOP; done; no tx_ready or rx_valid.
- tx_valid withheld 50 cycles in WR_WAIT -> SCL held low for the whole wait; transfer resumes and completes correctly.
- reset_n low in the middle of data bit 3 -> sda_oe = scl_oe = 0 asynchronously; busy=0. A new start afterwards runs a clean transfer. With CLK_STRETCH_EN: slave holds scl_i low 20 cycles -> bit is extended by 20 cycles.
